pal_config_loader: RTL
======================

Name: pal_config_loader

Overview:
Programming-side front end for the PAL OR plane. It accepts a serial fuse bitstream over a valid/ready handshake and assembles it into the per-output select matrix (SIZE rows of NUM_INPUTS bits). When the matrix is complete, it issues a single write-enable pulse so the OR array latches the whole matrix in one cycle. It sits between the configuration source (host/ROM streamer) and the OR array's sel/wen inputs.

Parameters:
NUM_INPUTS, 5, bits per row; the width of one output's select vector.
SIZE, 5, number of rows, i.e. OR-array outputs.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begins a load; sampled only in IDLE.
abort  input  1  cancels a load in progress; sampled only in LOAD.
cfg_data  input  1  serial fuse bit.
cfg_valid  input  1  cfg_data is valid this cycle.
cfg_ready  output  1  loader can accept a bit this cycle.
sel  output  SIZE*NUM_INPUTS  staging matrix, flattened; row r occupies bits [r*NUM_INPUTS +: NUM_INPUTS].
wen  output  1  one-cycle commit strobe to the OR array.
busy  output  1  high in LOAD and COMMIT.
done  output  1  one-cycle pulse after a successful commit.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=IDLE; sel=0; wen=0; cfg_ready=0; busy=0; done=0; bit_cnt=0; row_cnt=0. A reset mid-load or during COMMIT discards the partial matrix, and no wen is issued.
- Counters: bit_cnt is 0..NUM_INPUTS-1 and row_cnt is 0..SIZE-1, each $clog2 width with a minimum of 1.
- States are IDLE, LOAD, COMMIT and DONE.
- IDLE:
  - cfg_ready=0.
  - When start=1: clear sel to 0, clear both counters, and go to LOAD on the next cycle.
- LOAD:
  - cfg_ready=1 and busy=1.
  - A bit is accepted on a cycle where cfg_valid && cfg_ready. The accepted bit is written to sel[row_cnt*NUM_INPUTS + bit_cnt].
  - Stream order: row 0 first; within a row, bit 0 first (LSB first).
  - After an accept, bit_cnt increments. When bit_cnt wraps from NUM_INPUTS-1 to 0, row_cnt increments.
  - Accepting the final bit (row_cnt=SIZE-1, bit_cnt=NUM_INPUTS-1) moves the block to COMMIT on the next cycle. cfg_ready is 0 from that cycle onward.
  - cfg_valid=0 stalls the load indefinitely with no state change.
  - abort=1 returns to IDLE on the next cycle: sel is cleared, and neither wen nor done is asserted.
  - If abort=1 and an accept occur in the same cycle, abort wins: the bit is discarded and the block goes to IDLE.
- COMMIT:
  - Lasts exactly one cycle with wen=1 and busy=1; sel is stable and holds the complete matrix.
  - abort and start are ignored.
  - The next state is DONE.
- DONE:
  - Lasts one cycle with done=1, busy=0 and wen=0; the next state is IDLE.
  - sel retains the committed matrix until the next start or reset.
- Latency: if the last bit is accepted in cycle N, wen is high in cycle N+1, done is high in N+2, and IDLE is reached in N+3.
- start is ignored outside IDLE. start asserted during DONE is not queued.
- sel is only guaranteed to be meaningful while wen=1. The array must latch only on wen.
- Minimum load duration is SIZE*NUM_INPUTS accept cycles (25 with the defaults).

Test Plan:
1. Reset then start, streaming 25 bits with cfg_valid held high: rows 0..4 are 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, each sent LSB first. Required: cfg_ready is high for 25 cycles, then wen is high for exactly one cycle with sel=25'h1041041, then done pulses once the following cycle.
2. Same stream with cfg_valid deasserted every other cycle. Required: the same sel and a single wen, with wen occurring 1 cycle after the 25th accept.
3. Abort asserted after 12 accepted bits (all 1s). Required: the next state is IDLE, sel=0, and wen and done are never asserted. A subsequent full all-ones load gives sel=25'h1FFFFFF and a single wen.
4. abort=1 in the same cycle as the 25th cfg_valid. Required: the bit is not accepted, there is no wen, and the next state is IDLE.
5. rst pulsed for one cycle after 20 accepted bits. Required: sel=0, cfg_ready=0 and busy=0 on the cycle after reset; no wen appears within the next 10 cycles even if cfg_valid stays high.
6. start held high continuously through a full load. Required: exactly one wen per load, start is ignored in LOAD, COMMIT and DONE, and a new load begins only on the cycle after the block returns to IDLE, with sel cleared at that point.

Source files
------------

// File: rtl/pal_config_loader.sv
// Serial fuse-bitstream loader for the PAL OR plane. It assembles SIZE rows of
// NUM_INPUTS select bits, then strobes wen for one cycle so the array can latch them.
module pal_config_loader #(
  parameter int NUM_INPUTS = 5,
  parameter int SIZE       = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         cfg_data_i,
  input  logic                         cfg_valid_i,
  output logic                         cfg_ready_o,
  output logic [SIZE*NUM_INPUTS-1:0]   sel_o,
  output logic                         wen_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int N  = SIZE * NUM_INPUTS;
  localparam int BW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int RW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      sel_q, sel_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]     row_cnt_q, row_cnt_d;

  logic [NUM_INPUTS-1:0] bit_oh;
  logic [SIZE-1:0]       row_oh;
  logic [N-1:0]          wmask;
  logic                  last_bit, last_row;

  // One-hot write mask for the matrix cell addressed by the two counters.
  assign bit_oh = NUM_INPUTS'(1) << bit_cnt_q;
  assign row_oh = SIZE'(1) << row_cnt_q;

  for (genvar r = 0; r < SIZE; r++) begin : g_row
    assign wmask[r*NUM_INPUTS +: NUM_INPUTS] = row_oh[r] ? bit_oh : '0;
  end

  assign last_bit = (bit_cnt_q == BW'(NUM_INPUTS - 1));
  assign last_row = (row_cnt_q == RW'(SIZE - 1));

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    bit_cnt_d   = bit_cnt_q;
    row_cnt_d   = row_cnt_q;
    cfg_ready_o = 1'b0;
    wen_o       = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          sel_d     = '0;
          bit_cnt_d = '0;
          row_cnt_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        cfg_ready_o = 1'b1;
        busy_o      = 1'b1;
        // Abort takes priority over a bit presented in the same cycle.
        if (abort_i) begin
          sel_d     = '0;
          bit_cnt_d = '0;
          row_cnt_d = '0;
          state_d   = S_IDLE;
        end else if (cfg_valid_i) begin
          sel_d = (sel_q & ~wmask) | (wmask & {N{cfg_data_i}});
          if (last_bit) begin
            bit_cnt_d = '0;
            if (last_row) begin
              row_cnt_d = '0;
              state_d   = S_COMMIT;
            end else begin
              row_cnt_d = row_cnt_q + 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_COMMIT: begin
        wen_o   = 1'b1;
        busy_o  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      bit_cnt_q <= '0;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      bit_cnt_q <= bit_cnt_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  assign sel_o = sel_q;

endmodule
